// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32IM multi-cycle multiply/divide unit for the EX stage
module ex_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CMAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_dvd;      // dividend bits shift out the top, quotient bits shift in
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_div_signed;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [2*XLEN-1:0] w_a_wide;
    logic [2*XLEN-1:0] w_b_wide;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [XLEN-1:0]   w_q_next;
    logic [XLEN-1:0]   w_r_next;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic              w_load;
    logic [XLEN-1:0]   w_res_next;

    // Request decode and operand conditioning
    assign w_accept     = (r_state == S_IDLE) && start && !flush;
    assign w_div_signed = op[2] & ~op[0];
    assign w_abs1       = rs1[XLEN-1] ? ('0 - rs1) : rs1;
    assign w_abs2       = rs2[XLEN-1] ? ('0 - rs2) : rs2;
    assign w_div_zero   = (rs2 == '0);
    assign w_div_ovf    = ~op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    // Product path: operands widened to 2*XLEN so the low 2*XLEN bits of the
    // signed/unsigned product come out of a plain modular multiply
    assign w_a_sgn  = ((r_op == 2'b01) || (r_op == 2'b10)) & r_a[XLEN-1];
    assign w_b_sgn  = (r_op == 2'b01) & r_b[XLEN-1];
    assign w_a_wide = {{XLEN{w_a_sgn}}, r_a};
    assign w_b_wide = {{XLEN{w_b_sgn}}, r_b};
    assign w_prod   = w_a_wide * w_b_wide;

    // Restoring divider step; the true difference always fits in XLEN bits when non-negative
    assign w_rem_sh  = {r_rem, r_dvd[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub     = w_rem_sh[XLEN-1:0] - r_dvs;
    assign w_q_next  = {r_dvd[XLEN-2:0], w_ge};
    assign w_r_next  = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
    assign w_quo_fix = r_neg_q ? ('0 - w_q_next) : w_q_next;
    assign w_rem_fix = r_neg_r ? ('0 - w_r_next) : w_r_next;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and selection of the value captured on entry to DONE
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_res_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        w_state_next = S_MUL;
                    end else if (w_div_zero) begin
                        w_state_next = S_DONE;
                        w_load       = 1'b1;
                        w_res_next   = op[1] ? rs1 : '1;
                    end else if (w_div_ovf) begin
                        w_state_next = S_DONE;
                        w_load       = 1'b1;
                        w_res_next   = op[1] ? '0 : rs1;
                    end else begin
                        w_state_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                    w_load       = 1'b1;
                    w_res_next   = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                end
            end
            S_DIV: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                    w_load       = 1'b1;
                    w_res_next   = r_op[1] ? w_rem_fix : w_quo_fix;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
            w_load       = 1'b0;
        end
    end

    // Operand latching, iteration counter, divider registers and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op[1:0];
                r_a     <= rs1;
                r_b     <= rs2;
                r_cnt   <= op[2] ? CW'(XLEN - 1) : CW'(MUL_CYCLES - 1);
                r_dvd   <= w_div_signed ? w_abs1 : rs1;
                r_dvs   <= w_div_signed ? w_abs2 : rs2;
                r_rem   <= '0;
                r_neg_q <= w_div_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                r_neg_r <= w_div_signed & rs1[XLEN-1];
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                if (r_state == S_DIV) begin
                    r_dvd <= w_q_next;
                    r_rem <= w_r_next;
                end
            end
            if (w_load) begin
                r_result <= w_res_next;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE) && !flush;
    assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
    localparam int MC   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_CYCLES(MC)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: RISC-V M semantics via 64-bit integer math
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        case (f)
            3'd0: begin t = {32'b0, a} * {32'b0, b}; return t[31:0]; end
            3'd1: begin t = sa * sb; return t[63:32]; end
            3'd2: begin t = sa * longint'({32'b0, b}); return t[63:32]; end
            3'd3: begin t = {32'b0, a} * {32'b0, b}; return t[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; t = sa / sb; return t[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
            default: begin if (b == 0) return a; t = ua % longint'({32'b0, b}); return t[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MC + 1;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 20));
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation, then track latency, busy span, result stability and final value
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          cyc;
        int          busy_cyc;
        logic        seen;
        logic        held;
        logic [31:0] prev;
        @(negedge clk);
        prev  = result;
        start = 1'b1;
        op    = f;
        rs1   = a;
        rs2   = b;
        @(negedge clk);
        start    = 1'b0;
        op       = 3'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
        cyc      = 1;
        busy_cyc = 0;
        seen     = 1'b0;
        held     = 1'b1;
        while (cyc < 100) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (result !== prev) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(lat));
        check({tag, " result_held"}, 32'(held), 32'd1);
        check({tag, " result"}, result, exp);
        @(negedge clk);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " result_keep"}, result, exp);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prev;
        int          done_cnt;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        rs1   = '0;
        rs2   = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("MUL",      3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
        run_op("MULH",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
        run_op("MULHU",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        run_op("MULHSU",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        run_op("DIV",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("REM",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("DIVU",     3'd5, 32'd100,       32'd7,         32'h0000_000E, 33);
        run_op("REMU",     3'd7, 32'd100,       32'd7,         32'h0000_0002, 33);
        run_op("DIV0",     3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("REMU0",    3'd7, 32'd5,         32'd0,         32'd5,         1);
        run_op("DIV_OVF",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM_OVF",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            run_op($sformatf("rand%0d op%0d", i, f), f, a, b, ref_res(f, a, b), ref_lat(f, a, b));
        end

        // Flush during the 10th divide cycle
        @(negedge clk);
        prev  = result;
        start = 1'b1;
        op    = 3'd4;
        rs1   = 32'd1000;
        rs2   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, prev);
        done_cnt = 0;
        repeat (40) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("flush no_done", 32'(done_cnt), 32'd0);
        run_op("MULHU_after_flush", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);

        // Asynchronous reset mid-divide
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        rs1   = 32'd12345;
        rs2   = 32'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst done", 32'(done), 32'd0);
        check("async_rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Start held through DONE must not be taken
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        rs1   = 32'd5;
        rs2   = 32'd0;
        @(negedge clk);
        check("held done", 32'(done), 32'd1);
        check("held result", result, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b0;
        check("held ignored busy", 32'(busy), 32'd0);
        run_op("reissue", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
